// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the icache/dcache memory-port arbiter: FSM states,
// owner ids, request-type values and the beat-counter width helper.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WDATA = 2'd2,
      ST_RDATA = 2'd3
   } arb_state_e;

   localparam logic OWNER_IC     = 1'b0;
   localparam logic OWNER_DC     = 1'b1;
   localparam logic MEM_RW_READ  = 1'b0;
   localparam logic MEM_RW_WRITE = 1'b1;

   // One extra bit so the counter can hold BEATS itself and saturate there.
   function automatic int cnt_width(input int beats);
      return $clog2(beats) + 1;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Tie-break for the arbiter. Default build: dcache always wins a tie.
// With MEM_ARB_RR_EN defined, a last-grant pointer alternates tie winners.
module mem_arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic ic_req,
   input  logic dc_req,
   input  logic grant_en,
   output logic owner_pick
);

`ifdef MEM_ARB_RR_EN
   logic last_q;
   logic last_d;

   always_comb begin
      if (ic_req && dc_req) begin
         owner_pick = (last_q == OWNER_IC) ? OWNER_DC : OWNER_IC;
      end else begin
         owner_pick = dc_req ? OWNER_DC : OWNER_IC;
      end
      last_d = grant_en ? owner_pick : last_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= OWNER_IC;
      end else begin
         last_q <= last_d;
      end
   end
`else
   // Fixed priority needs no state; the pointer inputs are deliberately idle.
   logic unused_pick;
   assign unused_pick = clk ^ reset ^ ic_req ^ grant_en;

   always_comb begin
      owner_pick = dc_req ? OWNER_DC : OWNER_IC;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between icache refill and dcache refill/writeback,
// holding the grant for a whole BEATS-beat burst. Tie policy: MEM_ARB_RR_EN.
//   state    | meaning
//   ST_IDLE  | arbitrate, register owner
//   ST_REQ   | present owner's request to memory
//   ST_WDATA | forward dcache write beats
//   ST_RDATA | route read beats to owner
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 128,
   parameter int BEATS  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_req_valid,
   input  logic [ADDR_W-1:0] ic_req_addr,
   output logic              ic_req_ready,
   output logic              ic_resp_valid,
   output logic [DATA_W-1:0] ic_resp_data,
   input  logic              dc_req_valid,
   input  logic              dc_req_rw,
   input  logic [ADDR_W-1:0] dc_req_addr,
   output logic              dc_req_ready,
   input  logic              dc_wdata_valid,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic              dc_wdata_ready,
   output logic              dc_resp_valid,
   output logic [DATA_W-1:0] dc_resp_data,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_req_rw,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic              mem_wdata_valid,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_wdata_ready,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data
);

   localparam int               CNT_W     = cnt_width(BEATS);
   localparam logic [CNT_W-1:0] BEATS_C   = CNT_W'(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   arb_state_e       state_q, state_d;
   logic             owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pick;
   logic             grant_en;
   logic             req_rw;
   logic             beat_hs;

   assign grant_en = (state_q == ST_IDLE) && (ic_req_valid || dc_req_valid);
   assign req_rw   = (owner_q == OWNER_DC) ? dc_req_rw : MEM_RW_READ;

   mem_arb_pick u_pick (
      .clk        (clk),
      .reset      (reset),
      .ic_req     (ic_req_valid),
      .dc_req     (dc_req_valid),
      .grant_en   (grant_en),
      .owner_pick (pick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         owner_q <= OWNER_IC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      beat_hs = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_en) begin
               owner_d = pick;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (mem_req_ready) begin
               cnt_d   = '0;
               state_d = (req_rw == MEM_RW_WRITE) ? ST_WDATA : ST_RDATA;
            end
         end
         ST_WDATA: beat_hs = dc_wdata_valid && mem_wdata_ready;
         ST_RDATA: beat_hs = mem_resp_valid;
         default:  state_d = ST_IDLE;
      endcase
      if (beat_hs) begin
         cnt_d = (cnt_q == BEATS_C) ? cnt_q : cnt_q + CNT_W'(1);
         if (cnt_q == LAST_BEAT) begin
            state_d = ST_IDLE;
         end
      end
   end

   // Everything outside the active phase is held at zero, data included.
   always_comb begin
      ic_req_ready    = 1'b0;
      dc_req_ready    = 1'b0;
      ic_resp_valid   = 1'b0;
      ic_resp_data    = '0;
      dc_resp_valid   = 1'b0;
      dc_resp_data    = '0;
      dc_wdata_ready  = 1'b0;
      mem_req_valid   = 1'b0;
      mem_req_rw      = MEM_RW_READ;
      mem_req_addr    = '0;
      mem_wdata_valid = 1'b0;
      mem_wdata       = '0;
      case (state_q)
         ST_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_rw    = req_rw;
            mem_req_addr  = (owner_q == OWNER_DC) ? dc_req_addr : ic_req_addr;
            ic_req_ready  = (owner_q == OWNER_IC) && mem_req_ready;
            dc_req_ready  = (owner_q == OWNER_DC) && mem_req_ready;
         end
         ST_WDATA: begin
            mem_wdata_valid = dc_wdata_valid;
            mem_wdata       = dc_wdata;
            dc_wdata_ready  = mem_wdata_ready;
         end
         ST_RDATA: begin
            if (owner_q == OWNER_DC) begin
               dc_resp_valid = mem_resp_valid;
               dc_resp_data  = mem_resp_data;
            end else begin
               ic_resp_valid = mem_resp_valid;
               ic_resp_data  = mem_resp_data;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected requests/beats,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int AW = 32;
   localparam int DW = 128;
   localparam int NB = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          ic_req_valid, ic_req_ready, ic_resp_valid;
   logic [AW-1:0] ic_req_addr;
   logic [DW-1:0] ic_resp_data;
   logic          dc_req_valid, dc_req_rw, dc_req_ready;
   logic [AW-1:0] dc_req_addr;
   logic          dc_wdata_valid, dc_wdata_ready, dc_resp_valid;
   logic [DW-1:0] dc_wdata, dc_resp_data;
   logic          mem_req_valid, mem_req_ready, mem_req_rw;
   logic [AW-1:0] mem_req_addr;
   logic          mem_wdata_valid, mem_wdata_ready, mem_resp_valid;
   logic [DW-1:0] mem_wdata, mem_resp_data;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BEATS(NB)) dut (
      .clk(clk), .reset(reset),
      .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
      .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
      .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw), .dc_req_addr(dc_req_addr),
      .dc_req_ready(dc_req_ready), .dc_wdata_valid(dc_wdata_valid), .dc_wdata(dc_wdata),
      .dc_wdata_ready(dc_wdata_ready), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
      .mem_req_addr(mem_req_addr), .mem_wdata_valid(mem_wdata_valid), .mem_wdata(mem_wdata),
      .mem_wdata_ready(mem_wdata_ready), .mem_resp_valid(mem_resp_valid),
      .mem_resp_data(mem_resp_data)
   );

   typedef struct {
      logic          owner;
      logic [AW-1:0] addr;
      logic          rw;
   } req_t;

   req_t          exp_req[$];
   logic [DW-1:0] exp_ic[$];
   logic [DW-1:0] exp_dc[$];
   logic [DW-1:0] exp_w[$];

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int end_cyc = -1;
   int rcount = 0;
   int wcount = 0;
   bit gap_chk = 1'b0;
   logic prev_mreq = 1'b0;

   // bench-side cache / memory stub state
   int ic_pend = 0, dc_pend = 0, ic_n = 0, dc_n = 0, dc_wr_left = 0, wbeat = 0;
   int rd_left = 0, rd_idx = 0, req_wait = 0, req_stall = 0;
   int w_done = 0, wstall_after = -1, wstall_len = 0, wstall_cnt = 0;
   logic [AW-1:0] ic_base = '0, dc_base = '0, h_addr = '0, w_addr = '0;
   logic dc_rw_cfg = 1'b0;
   bit stray = 1'b0;

   function automatic logic [DW-1:0] beat_val(input logic [AW-1:0] a, input int i,
                                              input logic [7:0] tag);
      return {{(DW-AW-8){1'b0}}, a, tag + 8'(i)};
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic bound_chk(input string name, input bit ok);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      cyc++;
      if (mem_req_valid) begin
         if (!prev_mreq && gap_chk && end_cyc >= 0) chk("req_gap", cyc - end_cyc, 2);
         if (exp_req.size() == 0) begin
            chk("unexpected_req", mem_req_valid, 0);
         end else begin
            chk("req_addr", mem_req_addr, exp_req[0].addr);
            chk("req_rw", mem_req_rw, exp_req[0].rw);
            if (exp_req[0].owner == OWNER_IC) begin
               chk("req_rdy_owner", ic_req_ready, mem_req_ready);
               chk("req_rdy_other", dc_req_ready, 0);
            end else begin
               chk("req_rdy_owner", dc_req_ready, mem_req_ready);
               chk("req_rdy_other", ic_req_ready, 0);
            end
            if (mem_req_ready) void'(exp_req.pop_front());
         end
      end else begin
         chk("req_rdy_idle", {ic_req_ready, dc_req_ready}, 0);
      end
      prev_mreq = mem_req_valid;

      if (ic_resp_valid) begin
         if (exp_ic.size() == 0) chk("unexpected_ic_resp", ic_resp_valid, 0);
         else begin
            chk("ic_resp_data", ic_resp_data, exp_ic.pop_front());
            rcount++;
         end
      end
      if (dc_resp_valid) begin
         if (exp_dc.size() == 0) chk("unexpected_dc_resp", dc_resp_valid, 0);
         else begin
            chk("dc_resp_data", dc_resp_data, exp_dc.pop_front());
            rcount++;
         end
      end

      if (mem_wdata_valid) begin
         chk("wdata_ready_fwd", dc_wdata_ready, mem_wdata_ready);
         if (mem_wdata_ready) begin
            if (exp_w.size() == 0) chk("unexpected_wbeat", mem_wdata_valid, 0);
            else begin
               chk("wdata", mem_wdata, exp_w.pop_front());
               wcount++;
            end
         end
      end else begin
         chk("wdata_ready_off", dc_wdata_ready, 0);
      end

      if (rcount == NB) begin end_cyc = cyc; rcount = 0; end
      if (wcount == NB) begin end_cyc = cyc; wcount = 0; end
      if (reset) begin rcount = 0; wcount = 0; end
   end

   // ---------------- one clock of cache + memory stub ----------------
   task automatic tick();
      logic s_req_hs, s_rw, s_ic_hs, s_dc_hs, s_dcw_hs, s_mw_hs, s_resp, s_mreq, s_rst;
      logic [AW-1:0] s_addr;
      @(negedge clk);
      s_req_hs = mem_req_valid & mem_req_ready;
      s_rw     = mem_req_rw;
      s_addr   = mem_req_addr;
      s_ic_hs  = ic_req_valid & ic_req_ready;
      s_dc_hs  = dc_req_valid & dc_req_ready;
      s_dcw_hs = dc_wdata_valid & dc_wdata_ready;
      s_mw_hs  = mem_wdata_valid & mem_wdata_ready;
      s_resp   = mem_resp_valid;
      s_mreq   = mem_req_valid;
      s_rst    = reset;
      @(posedge clk);
      #1;
      if (s_ic_hs) begin ic_pend--; ic_n++; end
      if (s_dc_hs) begin
         if (dc_req_rw) begin dc_wr_left = NB; wbeat = 0; w_addr = dc_req_addr; end
         dc_pend--; dc_n++;
      end
      if (s_dcw_hs) begin wbeat++; dc_wr_left--; end
      if (s_resp && rd_left > 0) begin rd_left--; rd_idx++; end
      if (s_req_hs) begin
         req_wait = 0; w_done = 0; wstall_cnt = 0;
         if (s_rw == MEM_RW_READ) begin rd_left = NB; rd_idx = 0; h_addr = s_addr; end
      end else if (s_mreq) begin
         req_wait++;
      end
      if (s_mw_hs) w_done++;
      if (s_rst) begin ic_pend = 0; dc_pend = 0; dc_wr_left = 0; req_wait = 0; end

      ic_req_valid   = ic_pend > 0;
      ic_req_addr    = ic_base + 32'(ic_n * 64);
      dc_req_valid   = dc_pend > 0;
      dc_req_addr    = dc_base + 32'(dc_n * 64);
      dc_req_rw      = dc_rw_cfg;
      dc_wdata_valid = dc_wr_left > 0;
      dc_wdata       = (dc_wr_left > 0) ? beat_val(w_addr, wbeat, 8'hB0) : '0;
      mem_req_ready  = req_wait >= req_stall;
      mem_resp_valid = (rd_left > 0) || stray;
      mem_resp_data  = (rd_left > 0) ? beat_val(h_addr, rd_idx, 8'hA0) : {DW{1'b1}};
      stray = 1'b0;
      if (w_done == wstall_after && wstall_cnt < wstall_len) begin
         mem_wdata_ready = 1'b0;
         wstall_cnt++;
      end else begin
         mem_wdata_ready = 1'b1;
      end
   endtask

   task automatic push_req(input logic owner, input logic [AW-1:0] addr, input logic rw);
      req_t r;
      r.owner = owner; r.addr = addr; r.rw = rw;
      exp_req.push_back(r);
   endtask

   task automatic push_read(input logic owner, input logic [AW-1:0] addr);
      push_req(owner, addr, MEM_RW_READ);
      for (int i = 0; i < NB; i++) begin
         if (owner == OWNER_IC) exp_ic.push_back(beat_val(addr, i, 8'hA0));
         else exp_dc.push_back(beat_val(addr, i, 8'hA0));
      end
   endtask

   task automatic raise_ic(input logic [AW-1:0] base, input int n);
      ic_base = base; ic_n = 0; ic_pend = n;
      ic_req_addr = base; ic_req_valid = 1'b1;
   endtask

   task automatic raise_dc(input logic [AW-1:0] base, input int n);
      dc_base = base; dc_n = 0; dc_pend = n;
      dc_req_addr = base; dc_req_rw = dc_rw_cfg; dc_req_valid = 1'b1;
   endtask

   task automatic run_until_done(input string name, input int max);
      int k;
      k = 0;
      while (k < max && !(exp_req.size() == 0 && exp_ic.size() == 0 && exp_dc.size() == 0 &&
                          exp_w.size() == 0 && ic_pend == 0 && dc_pend == 0 &&
                          rd_left == 0 && dc_wr_left == 0)) begin
         tick();
         k++;
      end
      bound_chk(name, k < max);
   endtask

   task automatic check_idle(input string name);
      chk({name, "_vr"}, {ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid,
                          dc_wdata_ready, mem_req_valid, mem_wdata_valid}, 0);
      chk({name, "_addr"}, mem_req_addr, 0);
      chk({name, "_data"}, mem_wdata | ic_resp_data | dc_resp_data, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      ic_req_valid = 0; ic_req_addr = '0;
      dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0;
      dc_wdata_valid = 0; dc_wdata = '0;
      mem_req_ready = 0; mem_wdata_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
      repeat (3) tick();
      reset = 1'b0;
      #1 check_idle("reset_state");

      // IC-only read of 0x1000: beats ...A0..A3 on ic_resp only
      push_req(OWNER_IC, 32'h1000, MEM_RW_READ);
      exp_ic.push_back(128'h1000A0); exp_ic.push_back(128'h1000A1);
      exp_ic.push_back(128'h1000A2); exp_ic.push_back(128'h1000A3);
      raise_ic(32'h1000, 1);
      tick();
      #1 chk("arb_latency", mem_req_valid, 1);
      run_until_done("ic_read_done", 40);
      #1 check_idle("ic_read_idle");

      // DC write to 0x2000 with memory stalling 2 cycles after beat 2
      dc_rw_cfg = 1'b1;
      push_req(OWNER_DC, 32'h2000, MEM_RW_WRITE);
      exp_w.push_back(128'h2000B0); exp_w.push_back(128'h2000B1);
      exp_w.push_back(128'h2000B2); exp_w.push_back(128'h2000B3);
      wstall_after = 2; wstall_len = 2;
      raise_dc(32'h2000, 1);
      run_until_done("dc_write_done", 40);
      #1 check_idle("dc_write_idle");
      wstall_after = -1; dc_rw_cfg = 1'b0;

      // IC request stalled 5 cycles while DC asks; IC keeps the grant
      req_stall = 5;
      push_read(OWNER_IC, 32'h5000);
      push_read(OWNER_DC, 32'h6000);
      raise_ic(32'h5000, 1);
      tick(); tick();
      raise_dc(32'h6000, 1);
      run_until_done("req_stall_done", 80);
      #1 check_idle("req_stall_idle");
      req_stall = 0;

      // Back-to-back ties from reset (pointer at IC)
      reset = 1'b1; tick(); reset = 1'b0;
`ifdef MEM_ARB_RR_EN
      push_read(OWNER_DC, 32'h4000); push_read(OWNER_IC, 32'h3000);
      push_read(OWNER_DC, 32'h4040); push_read(OWNER_IC, 32'h3040);
`else
      push_read(OWNER_DC, 32'h4000); push_read(OWNER_DC, 32'h4040);
      push_read(OWNER_IC, 32'h3000); push_read(OWNER_IC, 32'h3040);
`endif
      end_cyc = -1; gap_chk = 1'b1;
      raise_ic(32'h3000, 2);
      raise_dc(32'h4000, 2);
      run_until_done("tie_done", 200);
      gap_chk = 1'b0;
      #1 check_idle("tie_idle");

      // Reset while the 2nd read beat is on the bus, then stray beats
      push_read(OWNER_IC, 32'h7000);
      raise_ic(32'h7000, 1);
      begin
         int k;
         k = 0;
         while (!(mem_resp_valid && rd_idx == 1) && k < 30) begin tick(); k++; end
         bound_chk("beat2_wait", k < 30);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_ic.delete(); exp_req.delete();
      #1 check_idle("reset_mid");
      chk("reset_mid_stray_present", mem_resp_valid, 1);
      tick(); tick();
      stray = 1'b1;
      tick();
      #1 check_idle("stray_idle");
      push_read(OWNER_DC, 32'h8000);
      raise_dc(32'h8000, 1);
      run_until_done("post_reset_done", 40);
      #1 check_idle("post_reset_idle");

      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one main-memory port between the instruction-cache refill path and the data-cache refill/writeback path. It sits between the cache controllers (behind the datapath's icache/dcache connections) and the memory system. It grants one requester at a time and holds the grant for a whole multi-beat transaction. It forwards the request, write-data and response handshakes to and from the owning cache only.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 128: beat width.
- `BEATS`, default 4: beats per transaction (≥1).
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `ic_req_valid` in 1: icache read request.
- `ic_req_addr` in ADDR_W: icache line address.
- `ic_req_ready` out 1: icache request accepted.
- `ic_resp_valid` out 1: icache read beat valid.
- `ic_resp_data` out DATA_W: icache read beat.
- `dc_req_valid` in 1: dcache request.
- `dc_req_rw` in 1: 1 = write, 0 = read.
- `dc_req_addr` in ADDR_W: dcache line address.
- `dc_req_ready` out 1: dcache request accepted.
- `dc_wdata_valid` in 1: dcache write beat valid.
- `dc_wdata` in DATA_W: dcache write beat.
- `dc_wdata_ready` out 1: dcache write beat accepted.
- `dc_resp_valid` out 1: dcache read beat valid.
- `dc_resp_data` out DATA_W: dcache read beat.
- `mem_req_valid` out 1: memory request.
- `mem_req_ready` in 1: memory accepts request.
- `mem_req_rw` out 1: memory request type.
- `mem_req_addr` out ADDR_W: memory address.
- `mem_wdata_valid` out 1: memory write beat valid.
- `mem_wdata` out DATA_W: memory write beat.
- `mem_wdata_ready` in 1: memory accepts beat.
- `mem_resp_valid` in 1: memory read beat valid (no backpressure).
- `mem_resp_data` in DATA_W: memory read beat.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - REQ: present the owner's request to memory.
  - WDATA: forward write beats.
  - RDATA: route read beats.
- IDLE: if any `*_req_valid` is high, register `owner` and go to REQ. Otherwise stay.
- REQ:
  - Memory request outputs: `mem_req_valid`=1, `mem_req_addr`=owner addr, `mem_req_rw`=(owner==DC)?`dc_req_rw`:0.
  - Owner ready: `ic_req_ready`/`dc_req_ready` = `mem_req_ready` for the owner, 0 for the other.
  - On handshake, clear the beat counter. Go to WDATA if rw=1, else RDATA.
  - Requesters hold valid/addr/rw stable until ready.
- WDATA:
  - Pass-through: `mem_wdata_valid`=`dc_wdata_valid`, `mem_wdata`=`dc_wdata`, `dc_wdata_ready`=`mem_wdata_ready`.
  - Each handshake counts one beat. The BEATS-th handshake returns to IDLE.
  - No response is generated for writes.
- RDATA:
  - `mem_resp_valid`/`mem_resp_data` route to the owner's `*_resp_*` only.
  - Each valid beat counts. The BEATS-th beat returns to IDLE.
- Outside RDATA, `mem_resp_valid` is ignored and both `*_resp_valid` stay 0.
- Outside WDATA, `dc_wdata_ready`=0 and `mem_wdata_valid`=0.
- The grant never changes mid-transaction. A new request from the non-owner waits.
- Beat counter: width clog2(BEATS)+1, saturates at BEATS, never wraps.

## Timing
- Reset values:
  - State IDLE, counter 0, `owner`=IC, last-grant pointer=IC.
  - All `*_valid` and `*_ready` outputs 0.
  - Data/addr outputs are don't-care but driven 0 in IDLE.
- Arbitration latency: request seen in IDLE → `mem_req_valid` high the next cycle.
- All ready/valid/data forwarding in REQ/WDATA/RDATA is combinational (same cycle).
- Last-beat cycle → IDLE next cycle. Minimum gap between transactions is 1 IDLE cycle.
- Reset mid-transaction: FSM goes to IDLE next cycle and all outputs drop. Memory is reset alongside, so stray beats afterwards are ignored by rule.

## Configuration
- `MEM_ARB_RR_EN` undefined: fixed priority. DC wins any tie in IDLE.
- `MEM_ARB_RR_EN` defined: round-robin.
  - A 1-bit last-grant pointer updates on every grant.
  - On a tie, the requester not granted last wins.
  - Pointer resets to IC, so the first tie goes to DC.
- Non-tie behaviour is identical in both builds.

## Structure
- Shared package/include: FSM state encodings, `OWNER_IC`=0/`OWNER_DC`=1, and `MEM_RW_READ`/`MEM_RW_WRITE` constants.
- Sub-module `mem_arb_pick`: tie-break logic, holding the round-robin pointer under the macro. FSM, counter and muxing stay in `mem_arbiter`.

## Test plan
- Icache-only read: IC read, addr 0x1000, BEATS=4.
  - `mem_req_valid` rises 1 cycle later with addr 0x1000, rw 0.
  - Beats 0xA0–0xA3 appear only on `ic_resp`; `dc_resp_valid` stays 0.
  - IDLE after the 4th beat.
- Fixed-priority tie: IC and DC reads raised in the same cycle → DC granted first; IC granted after DC's 4th beat plus 1 IDLE cycle.
- Round-robin ties (with `MEM_ARB_RR_EN`): three back-to-back ties → grant order DC, IC, DC.
- Write with memory stalls: DC write to 0x2000, `mem_wdata_ready` low for 2 cycles mid-burst.
  - Exactly 4 beats forwarded, in order.
  - No `*_resp_valid`; IDLE after the 4th handshake.
- Request stall: `mem_req_ready` held low for 5 cycles during an IC request while DC raises a request.
  - `mem_req_addr` stays stable and the owner stays IC.
  - Both ready outputs stay 0 until the accept.
- Reset and stray beats:
  - `reset` during RDATA beat 2 → all outputs 0 next cycle.
  - A stray `mem_resp_valid` in IDLE is ignored.
  - The next request is served normally.
